// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared FIFO pointer helpers and default sizing, used by both write- and read-side controllers.
package fifo_wr_ctrl_pkg;

  localparam int unsigned DefaultAddrWidth  = 3;
  localparam int unsigned DefaultSyncStages = 2;

  // Operands are zero-extended by the caller; the result is truncated back to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-bit flop chain for carrying a Gray pointer across clock domains; clears to zero on reset.
module fifo_ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: binary/Gray write pointer, full, overflow pulse.
// Define FIFO_ALMOST_FULL_EN to build the occupancy-based almost_full flag; otherwise it is tied low.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned AF_MARGIN   = 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_inc,
  input  logic [ADDR_WIDTH:0]   R_gray_ptr,
  output logic [ADDR_WIDTH-1:0] W_addr,
  output logic [ADDR_WIDTH:0]   W_gray_ptr,
  output logic                  full,
  output logic                  W_ovf,
  output logic                  almost_full
);

  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [PtrW-1:0] wbin_q;
  logic [PtrW-1:0] wbin_next;
  logic [PtrW-1:0] gray_next;
  logic [PtrW-1:0] rq_sync;
  logic [PtrW-1:0] full_cmp;
  logic            accept;

  fifo_ptr_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (W_CLK),
    .rst_n (W_RST),
    .d     (R_gray_ptr),
    .q     (rq_sync)
  );

  assign accept    = W_inc & ~full;
  assign wbin_next = wbin_q + PtrW'(accept);
  assign gray_next = PtrW'(bin2gray(32'(wbin_next)));
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign full_cmp  = {~rq_sync[PtrW-1 -: 2], rq_sync[PtrW-3:0]};
  assign W_addr    = wbin_q[ADDR_WIDTH-1:0];

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q     <= '0;
      W_gray_ptr <= '0;
      full       <= 1'b0;
      W_ovf      <= 1'b0;
    end else begin
      wbin_q     <= wbin_next;
      W_gray_ptr <= gray_next;
      full       <= (gray_next == full_cmp);
      W_ovf      <= W_inc & full;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic [PtrW-1:0] rbin_sync;
  logic [PtrW-1:0] occupancy;

  assign rbin_sync = PtrW'(gray2bin(32'(rq_sync)));
  assign occupancy = wbin_next - rbin_sync;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (occupancy >= PtrW'(Depth - AF_MARGIN));
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: counter-based FIFO model, randomized writes and reads.
module tb_fifo_wr_ctrl;

  localparam int unsigned AW      = 3;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned MARGIN  = 2;
  localparam int          DEPTH   = 2 ** AW;
`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AfEn = 1'b1;
`else
  localparam bit AfEn = 1'b0;
`endif

  logic          W_CLK = 1'b0;
  logic          W_RST = 1'b0;
  logic          W_inc = 1'b0;
  logic [AW:0]   R_gray_ptr = '0;
  logic [AW-1:0] W_addr;
  logic [AW:0]   W_gray_ptr;
  logic          full;
  logic          W_ovf;
  logic          almost_full;

  fifo_wr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SYNC),
    .AF_MARGIN   (MARGIN)
  ) dut (
    .W_CLK       (W_CLK),
    .W_RST       (W_RST),
    .W_inc       (W_inc),
    .R_gray_ptr  (R_gray_ptr),
    .W_addr      (W_addr),
    .W_gray_ptr  (W_gray_ptr),
    .full        (full),
    .W_ovf       (W_ovf),
    .almost_full (almost_full)
  );

  always #5 W_CLK = ~W_CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   gray;
    logic          full;
    logic          ovf;
    logic          af;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain counts of writes accepted and reads seen through the sync delay.
  int   m_w;
  int   rc;
  bit   m_full;
  int   rhist[$];

  function automatic logic [AW:0] gray_of(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0;
    rc = 0;
    m_full = 1'b0;
    rhist.delete();
    for (int i = 0; i < int'(SYNC); i++) rhist.push_back(0);
  endtask

  task automatic step(input bit inc, input int rcount);
    int   rs;
    int   occ;
    bit   acc;
    exp_t e;
    @(negedge W_CLK);
    W_inc = inc;
    rc = rcount;
    R_gray_ptr = gray_of(rcount);
    rs = rhist.pop_front();
    rhist.push_back(rcount);
    acc = inc && !m_full;
    e.ovf = inc && m_full;
    m_w = m_w + int'(acc);
    occ = m_w - rs;
    m_full = (occ == DEPTH);
    e.full = m_full;
    e.af = AfEn && (occ >= DEPTH - int'(MARGIN));
    e.addr = AW'(m_w % DEPTH);
    e.gray = gray_of(m_w);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(W_addr), 32'd0);
    check({tag, "_gray"}, 32'(W_gray_ptr), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_ovf"},  32'(W_ovf), 32'd0);
    check({tag, "_af"},   32'(almost_full), 32'd0);
  endtask

  // Monitor: compares every post-edge DUT state against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge W_CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("addr", 32'(W_addr), 32'(e.addr));
        check("gray", 32'(W_gray_ptr), 32'(e.gray));
        check("full", 32'(full), 32'(e.full));
        check("ovf", 32'(W_ovf), 32'(e.ovf));
        check("almost_full", 32'(almost_full), 32'(e.af));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_reset_outputs("por");
    @(negedge W_CLK);
    W_RST = 1'b1;

    // Fill 8 with no reads, then two overflow attempts.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0);
    step(1'b1, 0);
    step(1'b1, 0);
    // Release one slot; full drops SYNC+1 edges later, then a write is accepted.
    step(1'b0, 1);
    step(1'b0, 1);
    step(1'b0, 1);
    step(1'b1, 1);
    step(1'b0, 1);

    // Drain, then write with the reader one entry behind across the pointer wrap.
    while (rc < m_w) step(1'b0, rc + 1);
    for (int i = 0; i < 20; i++) step(1'b1, (m_w > 0) ? m_w - 1 : 0);

    // Random traffic: slow reader first to hit full often, then a fast reader.
    for (int i = 0; i < 400; i++) begin
      bit inc;
      int rd_pct;
      int nrc;
      rd_pct = (i < 200) ? 30 : 75;
      inc = ($urandom_range(0, 99) < 70);
      nrc = rc;
      if (rc < m_w && $urandom_range(0, 99) < rd_pct) nrc = rc + 1;
      step(inc, nrc);
    end

    // Mid-run asynchronous reset with 5 unread entries.
    while (rc < m_w) step(1'b0, rc + 1);
    for (int i = 0; i < 5; i++) step(1'b1, rc);
    @(negedge W_CLK);
    W_inc = 1'b0;
    #2;
    W_RST = 1'b0;
    R_gray_ptr = '0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge W_CLK);
    W_RST = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 0);
    step(1'b0, 0);
    @(posedge W_CLK);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, memory address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 Parameter SYNC_STAGES, default 2, flop count of read-pointer synchronizer (min 2).
REQ-003 Parameter AF_MARGIN, default 2, free-slot margin for almost_full.
REQ-004 W_CLK  in  1  write-domain clock; all state SHALL be clocked on its rising edge.
REQ-005 W_RST  in  1  reset, asynchronous, active-low.
REQ-006 W_inc  in  1  write request from producer, sampled on W_CLK rising edge.
REQ-007 R_gray_ptr  in  ADDR_WIDTH+1  Gray-coded read pointer from read domain, asynchronous to W_CLK.
REQ-008 W_addr  out  ADDR_WIDTH  write address to FIFO memory.
REQ-009 W_gray_ptr  out  ADDR_WIDTH+1  registered Gray write pointer toward read domain.
REQ-010 full  out  1  registered full flag to memory and producer.
REQ-011 W_ovf  out  1  one-cycle pulse on write attempt while full.
REQ-012 almost_full  out  1  occupancy at or above DEPTH-AF_MARGIN.

Function
REQ-013 Binary write pointer wbin SHALL be ADDR_WIDTH+1 bits; W_addr = wbin[ADDR_WIDTH-1:0].
REQ-014 Accepted write = W_inc & ~full; wbin SHALL increment by 1 per accepted write, modulo 2**(ADDR_WIDTH+1), wrapping 1111->0000 at ADDR_WIDTH=3.
REQ-015 W_inc while full SHALL leave wbin, W_gray_ptr, W_addr unchanged and set W_ovf=1 for exactly the next cycle.
REQ-016 W_gray_ptr SHALL be registered from wbin_next ^ (wbin_next >> 1); only one bit changes per accepted write.
REQ-017 R_gray_ptr SHALL pass through SYNC_STAGES flops before any use (rq_sync); no combinational path from R_gray_ptr to outputs.
REQ-018 full SHALL be registered as (gray(wbin_next) == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}).
REQ-019 full SHALL assert in the cycle following the edge accepting the DEPTH-th unread write (zero-cycle lag vs. pointer).
REQ-020 full SHALL deassert exactly SYNC_STAGES+1 W_CLK edges after R_gray_ptr advances, pessimistic by design.
REQ-021 Simultaneous accepted write and synchronized read advance SHALL keep full computed from both new values in the same cycle.
REQ-022 Block SHALL never accept more than DEPTH unread entries regardless of W_inc pattern.

Reset
REQ-023 W_RST low SHALL asynchronously clear wbin, W_gray_ptr, W_addr, full, W_ovf, almost_full, all synchronizer flops to 0.
REQ-024 Reset SHALL be deasserted synchronously to W_CLK externally; mid-operation reset discards pointer state, no partial write issued.

Configuration
REQ-025 Macro FIFO_ALMOST_FULL_EN defined: gray-to-binary conversion of rq_sync, occupancy = wbin_next - rbin_sync (ADDR_WIDTH+1 bits, modulo), almost_full registered as occupancy >= DEPTH-AF_MARGIN.
REQ-026 Macro undefined: almost_full port present, tied to 0, no conversion/subtract logic synthesized.

Structure
REQ-027 Shared package: bin2gray/gray2bin functions, default ADDR_WIDTH and SYNC_STAGES constants, shared with read-side controller.
REQ-028 One sub-module fifo_ptr_sync: parameterized multi-bit, SYNC_STAGES-deep flop chain, async active-low reset to 0.

Verification (ADDR_WIDTH=3, DEPTH=8, SYNC_STAGES=2, AF_MARGIN=2)
REQ-029 Reset: W_RST=0 mid-run with 5 entries -> W_addr=0, W_gray_ptr=0000, full=0, W_ovf=0 immediately, no clock.
REQ-030 Fill: R_gray_ptr=0000, 8 consecutive W_inc -> W_addr 0..7 then 0, W_gray_ptr=1100, full=1 after 8th edge.
REQ-031 Overflow: full=1, W_inc=1 for 2 cycles -> W_addr held at 0, W_ovf=1 for each attempt, pointer unchanged.
REQ-032 Release: full=1, R_gray_ptr 0000->0001 -> full=0 exactly 3 W_CLK edges later, next W_inc accepted.
REQ-033 Wrap: 20 writes with R_gray_ptr tracking 1 behind -> wbin wraps 1111->0000, W_gray_ptr 1000->0000, full never 1.
REQ-034 Macro: FIFO_ALMOST_FULL_EN, R_gray_ptr=0000, 6 writes -> almost_full=1 after 6th edge, 0 after 5th; undefined -> almost_full stays 0.
